// File: rtl/pacman_soc_nios2_gen2_0_cpu_debug_ocimem_pkg.sv
// Shared types and constants for the Nios II debug on-chip memory stage.
//   state_e      : controller FSM states
//   strobe_e     : decoded JTAG strobe kind (also the pending-slot encoding)
//   JDO_*        : bit positions of the address/data fields inside jdo
//   strobe_kind(): collapses simultaneous strobes to one kind, b > a > no_action_a
package pacman_soc_nios2_gen2_0_cpu_debug_ocimem_pkg;

  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 9;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;

  typedef enum logic [2:0] {
    IDLE,
    J_RD,
    J_RD_CAP,
    J_WR,
    C_RD,
    C_DONE
  } state_e;

  typedef enum logic [1:0] {
    STB_NONE,
    STB_SETADDR_RD,
    STB_INC_RD,
    STB_WR
  } strobe_e;

  function automatic strobe_e strobe_kind(input logic act_a, input logic noact_a,
                                          input logic act_b);
    if (act_b)        return STB_WR;
    else if (act_a)   return STB_SETADDR_RD;
    else if (noact_a) return STB_INC_RD;
    else              return STB_NONE;
  endfunction

endpackage

// File: rtl/pacman_soc_nios2_gen2_0_cpu_debug_ocimem_ram.sv
// Single-port synchronous debug RAM, 32-bit words, byte-lane writes.
//   clk      : clock
//   addr_i   : word address (read and write share it)
//   we_i     : write enable
//   be_i     : byte-lane enables for the write
//   wdata_i  : write data
//   rdata_o  : read data, valid one cycle after addr_i (old data on read-during-write)
// Contents are deliberately not reset.
module pacman_soc_nios2_gen2_0_cpu_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pacman_soc_nios2_gen2_0_cpu_debug_ocimem.sv
// Debug on-chip memory stage: arbitrates one debug RAM between JTAG monitor
// strobes (priority) and the CPU Avalon debug-memory slave.
//   clk, reset_n                  : clock, async active-low reset
//   jdo                           : JTAG data (address at [ADDR_W+8:9], data at [34:3])
//   take_action_ocimem_a          : load MonAReg from jdo, then JTAG read
//   take_no_action_ocimem_a       : MonAReg+1, then JTAG read
//   take_action_ocimem_b          : JTAG write of jdo data at MonAReg, then MonAReg+1
//   address/chipselect/read/write/writedata/byteenable/debugaccess : CPU slave in
//   readdata, waitrequest         : CPU slave out
//   MonDReg, MonAReg              : monitor data/address registers
//   jtag_busy                     : JTAG op in flight or pending
//   jtag_ovf                      : sticky, a strobe was lost because pending was full
//
// state    | meaning
// IDLE     | arbitrate: pending strobe, new strobe, then CPU
// J_RD     | RAM read at MonAReg issued
// J_RD_CAP | RAM data captured into MonDReg
// J_WR     | MonDReg written at MonAReg, MonAReg advances
// C_RD     | RAM read at CPU address issued
// C_DONE   | CPU read completes (waitrequest low)
module pacman_soc_nios2_gen2_0_cpu_debug_ocimem
  import pacman_soc_nios2_gen2_0_cpu_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [DATA_W-1:0] readdata,
  output logic              waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_busy,
  output logic              jtag_ovf
);

  state_e            state_q, state_d;
  strobe_e           pend_kind_q, pend_kind_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [DATA_W-1:0] mon_d_q, mon_d_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ovf_q, ovf_d;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  strobe_e           in_kind, take_kind;
  logic [ADDR_W-1:0] in_addr, take_addr;
  logic [DATA_W-1:0] in_data, take_data;
  logic              pend_valid;
  logic              unused_jdo;

  assign in_kind    = strobe_kind(take_action_ocimem_a, take_no_action_ocimem_a,
                                  take_action_ocimem_b);
  assign in_addr    = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign in_data    = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_DATA_MSB+1], jdo[JDO_DATA_LSB-1:0]};

  assign pend_valid = (pend_kind_q != STB_NONE);
  // A pending strobe is always older than one arriving now, so it wins in IDLE.
  assign take_kind  = pend_valid ? pend_kind_q : in_kind;
  assign take_addr  = pend_valid ? pend_addr_q : in_addr;
  assign take_data  = pend_valid ? pend_data_q : in_data;

  always_comb begin
    state_d     = state_q;
    pend_kind_d = pend_kind_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    rdata_d     = rdata_q;
    ovf_d       = ovf_q;
    ram_addr    = address;
    ram_we      = 1'b0;
    ram_be      = 4'hF;
    ram_wdata   = mon_d_q;
    waitrequest = 1'b1;

    case (state_q)
      IDLE: begin
        if (take_kind != STB_NONE) begin
          // Serving the pending slot frees it; a strobe arriving now refills it.
          if (pend_valid) begin
            pend_kind_d = in_kind;
            pend_addr_d = in_addr;
            pend_data_d = in_data;
          end
          case (take_kind)
            STB_SETADDR_RD: begin
              mon_a_d = take_addr;
              state_d = J_RD;
            end
            STB_INC_RD: begin
              mon_a_d = mon_a_q + 1'b1;
              state_d = J_RD;
            end
            STB_WR: begin
              mon_d_d = take_data;
              state_d = J_WR;
            end
            default: ;
          endcase
        end else if (chipselect && read) begin
          state_d = C_RD;
        end else if (chipselect && write) begin
          waitrequest = 1'b0;
          if (debugaccess) begin
            ram_we    = 1'b1;
            ram_be    = byteenable;
            ram_wdata = writedata;
          end
        end
      end
      J_RD: begin
        ram_addr = mon_a_q;
        state_d  = J_RD_CAP;
      end
      J_RD_CAP: begin
        mon_d_d = ram_rdata;
        state_d = IDLE;
      end
      J_WR: begin
        ram_addr = mon_a_q;
        ram_we   = 1'b1;
        mon_a_d  = mon_a_q + 1'b1;
        state_d  = IDLE;
      end
      C_RD: begin
        state_d = C_DONE;
      end
      C_DONE: begin
        waitrequest = 1'b0;
        rdata_d     = ram_rdata;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && in_kind != STB_NONE) begin
      if (!pend_valid) begin
        pend_kind_d = in_kind;
        pend_addr_d = in_addr;
        pend_data_d = in_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_kind_q <= STB_NONE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      rdata_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_kind_q <= pend_kind_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      rdata_q     <= rdata_d;
      ovf_q       <= ovf_d;
    end
  end

  pacman_soc_nios2_gen2_0_cpu_debug_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // RAM data is presented straight through in C_DONE so it is valid in the
  // same cycle waitrequest drops; the register holds it afterwards.
  assign readdata  = (state_q == C_DONE) ? ram_rdata : rdata_q;
  assign MonDReg   = mon_d_q;
  assign MonAReg   = mon_a_q;
  assign jtag_busy = (state_q == J_RD) || (state_q == J_RD_CAP) || (state_q == J_WR) || pend_valid;
  assign jtag_ovf  = ovf_q;

endmodule

// File: tb/tb_pacman_soc_nios2_gen2_0_cpu_debug_ocimem.sv
module tb_pacman_soc_nios2_gen2_0_cpu_debug_ocimem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, tna_a, ta_b;
  logic [7:0]  address;
  logic        chipselect, read, write, debugaccess;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata, MonDReg;
  logic [7:0]  MonAReg;
  logic        waitrequest, jtag_busy, jtag_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: RAM image and monitor registers.
  logic [31:0] mem [256];
  logic [7:0]  m_a;
  logic [31:0] m_d;

  always #5 clk = ~clk;

  pacman_soc_nios2_gen2_0_cpu_debug_ocimem #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .address                 (address),
    .chipselect              (chipselect),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .jtag_busy               (jtag_busy),
    .jtag_ovf                (jtag_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] rand_jdo();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[37:0];
  endfunction

  task automatic jtag_write(input logic [31:0] d);
    logic [37:0] j;
    j = rand_jdo();
    j[34:3] = d;
    jdo = j; ta_b = 1'b1;
    step();
    ta_b = 1'b0;
    step();
    mem[m_a] = d; m_d = d; m_a = m_a + 8'd1;
    chk("jwr_areg", 32'(MonAReg), 32'(m_a));
    chk("jwr_dreg", MonDReg, m_d);
  endtask

  task automatic jtag_read_addr(input logic [7:0] a);
    logic [37:0] j;
    logic [31:0] old_d;
    old_d = m_d;
    j = rand_jdo();
    j[16:9] = a;
    jdo = j; ta_a = 1'b1;
    step();
    ta_a = 1'b0;
    step();
    chk("jrd_early", MonDReg, old_d);
    step();
    m_a = a; m_d = mem[a];
    chk("jrd_areg", 32'(MonAReg), 32'(m_a));
    chk("jrd_dreg", MonDReg, m_d);
  endtask

  task automatic jtag_read_inc();
    jdo = rand_jdo(); tna_a = 1'b1;
    step();
    tna_a = 1'b0;
    step();
    step();
    m_a = m_a + 8'd1; m_d = mem[m_a];
    chk("jinc_areg", 32'(MonAReg), 32'(m_a));
    chk("jinc_dreg", MonDReg, m_d);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg);
    address = a; writedata = d; byteenable = be; debugaccess = dbg;
    chipselect = 1'b1; write = 1'b1;
    #1;
    chk("cwr_wait", 32'(waitrequest), 32'd0);
    step();
    chipselect = 1'b0; write = 1'b0;
    if (dbg) for (int i = 0; i < 4; i++) if (be[i]) mem[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic cpu_read(input logic [7:0] a);
    address = a; chipselect = 1'b1; read = 1'b1;
    #1;
    chk("crd_wait_n0", 32'(waitrequest), 32'd1);
    step();
    chk("crd_wait_n1", 32'(waitrequest), 32'd1);
    step();
    chk("crd_wait_n2", 32'(waitrequest), 32'd0);
    chk("crd_data", readdata, mem[a]);
    step();
    chipselect = 1'b0; read = 1'b0;
    #1;
    chk("crd_wait_after", 32'(waitrequest), 32'd1);
  endtask

  initial begin
    logic [31:0] orig, d;
    logic [37:0] j;
    logic [7:0]  p, q, x;
    int          edges;

    reset_n = 1'b0; jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0;
    address = '0; chipselect = 0; read = 0; write = 0; writedata = '0;
    byteenable = '0; debugaccess = 0;
    m_a = 8'd0; m_d = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step();

    chk("rst_dreg", MonDReg, 32'd0);
    chk("rst_areg", 32'(MonAReg), 32'd0);
    chk("rst_wait", 32'(waitrequest), 32'd1);
    chk("rst_ovf", 32'(jtag_ovf), 32'd0);
    chk("rst_busy", 32'(jtag_busy), 32'd0);
    chk("rst_rdata", readdata, 32'd0);

    // Fill the whole RAM through JTAG so every later read has a known value.
    for (int i = 0; i < 256; i++) jtag_write($urandom);
    chk("fill_wrap", 32'(MonAReg), 32'd0);

    // Write then read back.
    jtag_read_addr(8'h10);
    jtag_write(32'hDEADBEEF);
    chk("wb_areg", 32'(MonAReg), 32'h11);
    jtag_read_addr(8'h10);
    chk("wb_data", MonDReg, 32'hDEADBEEF);

    // Address wrap.
    jtag_read_addr(8'hFF);
    jtag_read_inc();
    chk("wrap_areg", 32'(MonAReg), 32'h00);

    // CPU byte-lane write, blocked write, read latency.
    orig = mem[8'h20];
    cpu_write(8'h20, 32'h12345678, 4'b0011, 1'b1);
    cpu_read(8'h20);
    chk("cpu_bytes", readdata, {orig[31:16], 16'h5678});
    cpu_write(8'h20, 32'hAAAAAAAA, 4'hF, 1'b0);
    cpu_read(8'h20);
    chk("cpu_nodbg", readdata, {orig[31:16], 16'h5678});
    jtag_read_addr(8'h20);

    // Simultaneous strobes: the write wins.
    d = $urandom;
    j = rand_jdo(); j[34:3] = d;
    jdo = j; ta_a = 1; tna_a = 1; ta_b = 1;
    step();
    ta_a = 0; tna_a = 0; ta_b = 0;
    step();
    mem[m_a] = d; m_d = d; m_a = m_a + 8'd1;
    chk("prio_areg", 32'(MonAReg), 32'(m_a));
    chk("prio_dreg", MonDReg, m_d);
    jtag_read_addr(m_a - 8'd1);

    // Collision: JTAG read first (3 cycles), then CPU read completes 2 cycles later.
    p = 8'($urandom); q = 8'($urandom);
    address = p; chipselect = 1; read = 1;
    j = rand_jdo(); j[16:9] = q;
    jdo = j; ta_a = 1;
    step();
    ta_a = 0;
    edges = 1;
    while (waitrequest !== 1'b0 && edges < 20) begin
      step();
      edges++;
    end
    chk("col_edges", 32'(edges), 32'd5);
    chk("col_rdata", readdata, mem[p]);
    m_a = q; m_d = mem[q];
    chk("col_dreg", MonDReg, m_d);
    chk("col_areg", 32'(MonAReg), 32'(m_a));
    step();
    chipselect = 0; read = 0;

    // Overflow: first runs, second pends, third is dropped.
    x = 8'($urandom);
    j = rand_jdo(); j[16:9] = x;
    jdo = j; ta_a = 1;
    step();
    ta_a = 0; tna_a = 1;
    step();
    tna_a = 0; jdo = rand_jdo(); ta_b = 1;
    step();
    ta_b = 0;
    chk("ovf_set", 32'(jtag_ovf), 32'd1);
    chk("ovf_busy_pend", 32'(jtag_busy), 32'd1);
    chk("ovf_first", MonDReg, mem[x]);
    step(); step(); step();
    m_a = x + 8'd1; m_d = mem[m_a];
    chk("ovf_pend_areg", 32'(MonAReg), 32'(m_a));
    chk("ovf_pend_dreg", MonDReg, m_d);
    chk("ovf_busy_done", 32'(jtag_busy), 32'd0);
    chk("ovf_sticky", 32'(jtag_ovf), 32'd1);
    jtag_read_inc();

    // Randomized mix against the model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: jtag_write($urandom);
        1: jtag_read_addr(8'($urandom));
        2: jtag_read_inc();
        3: cpu_write(8'($urandom), $urandom, 4'($urandom), 1'($urandom));
        default: cpu_read(8'($urandom));
      endcase
    end
    chk("mix_ovf_sticky", 32'(jtag_ovf), 32'd1);

    // Async reset during J_RD_CAP.
    x = 8'($urandom);
    j = rand_jdo(); j[16:9] = x;
    jdo = j; ta_a = 1;
    step();
    ta_a = 0;
    step();
    chk("arst_busy_pre", 32'(jtag_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_dreg", MonDReg, 32'd0);
    chk("arst_areg", 32'(MonAReg), 32'd0);
    chk("arst_wait", 32'(waitrequest), 32'd1);
    chk("arst_busy", 32'(jtag_busy), 32'd0);
    chk("arst_ovf", 32'(jtag_ovf), 32'd0);
    chk("arst_rdata", readdata, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    step();
    m_a = 8'd0; m_d = 32'd0;
    chk("post_areg", 32'(MonAReg), 32'd0);
    cpu_read(8'($urandom));
    jtag_read_inc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pacman_soc_nios2_gen2_0_cpu_debug_ocimem.md
Name: pacman_soc_nios2_gen2_0_cpu_debug_ocimem

Overview:
Debug on-chip memory stage of the Nios II debug path. It sits directly downstream of the debug-slave sysclk stage: it consumes jdo and the take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a strobes. It produces MonDReg, which feeds back into the debug-slave scan chain. It owns a single-port debug RAM that is shared between JTAG monitor accesses and the CPU's Avalon debug-memory slave port; JTAG has priority.

Parameters:
ADDR_W, 8, word-address width; RAM depth is 2**ADDR_W words.
DATA_W, 32, data width; fixed at 32 because jdo field positions depend on it.

Ports:
clk  in  1  system clock; all logic is on this clock.
reset_n  in  1  asynchronous, active-low reset.
jdo  in  38  JTAG data captured by the sysclk stage.
take_action_ocimem_a  in  1  1-cycle strobe: load address from jdo[ADDR_W+8:9], then JTAG read.
take_no_action_ocimem_a  in  1  1-cycle strobe: MonAReg+1, then JTAG read.
take_action_ocimem_b  in  1  1-cycle strobe: JTAG write of jdo[34:3] at MonAReg.
address  in  ADDR_W  CPU word address.
chipselect  in  1  CPU slave select.
read  in  1  CPU read request.
write  in  1  CPU write request.
writedata  in  32  CPU write data.
byteenable  in  4  CPU byte lanes.
debugaccess  in  1  CPU write permitted only when 1.
readdata  out  32  CPU read data.
waitrequest  out  1  Avalon waitrequest.
MonDReg  out  32  monitor data register returned to the scan chain.
MonAReg  out  ADDR_W  monitor address register.
jtag_busy  out  1  1 whenever the FSM is in a J_* state.
jtag_ovf  out  1  sticky strobe-overflow flag.

Behaviour:
- Reset values: MonDReg=0, MonAReg=0, readdata=0, waitrequest=1, jtag_busy=0, jtag_ovf=0, pending=empty, FSM=IDLE. RAM contents are not reset.
- Reset asserted mid-operation aborts the access immediately. A RAM write already clocked in that cycle stands; nothing else is retried.
- RAM: synchronous read with 1-cycle latency. Writes are per byte lane: JTAG always uses byte-enable 4'hF; the CPU uses byteenable.
- Strobe priority when several strobes are high in the same cycle: b > a > no_action_a. Only one is taken; the rest are dropped silently.
- Address arithmetic: MonAReg increments modulo 2**ADDR_W, so 0xFF+1 = 0x00 at ADDR_W=8.
- FSM states: IDLE, J_RD, J_RD_CAP, J_WR, C_RD, C_DONE.
- IDLE, strobe a: MonAReg<=jdo[ADDR_W+8:9], go to J_RD.
- IDLE, strobe no_action_a: MonAReg<=MonAReg+1, go to J_RD.
- IDLE, strobe b: MonDReg<=jdo[34:3], go to J_WR.
- IDLE, CPU (chipselect & read) with no strobe: go to C_RD.
- IDLE, CPU (chipselect & write & debugaccess) with no strobe: RAM write this cycle, waitrequest=0 this cycle (single-cycle write), stay in IDLE.
- IDLE, CPU write with debugaccess=0: completes with waitrequest=0 and no RAM write.
- J_RD: issue RAM read at MonAReg, go to J_RD_CAP.
- J_RD_CAP: MonDReg<=RAM data (2 cycles after the strobe), go to IDLE.
- J_WR: RAM write MonDReg at MonAReg; MonAReg<=MonAReg+1; go to IDLE.
- C_RD: issue RAM read at address, go to C_DONE.
- C_DONE: readdata<=RAM data, waitrequest=0 for exactly this cycle, go to IDLE.
- CPU read latency with no contention: request in cycle N; waitrequest=0 with valid readdata in cycle N+2.
- waitrequest is 1 in every cycle that does not complete a CPU access, including when CPU and strobe collide in IDLE. The JTAG operation runs first; the CPU holds its request until served.
- Strobe arriving in a non-IDLE state is stored in a one-deep pending register, with the same priority rule. Pending is served on the next IDLE, ahead of the CPU.
- Strobe arriving while pending is already full: dropped; jtag_ovf<=1 and stays 1 until reset.
- jtag_busy=1 in J_RD, J_RD_CAP and J_WR, and also while pending is full.

Decomposition:
- Shared package holds: FSM state enum; jdo field constants (JDO_ADDR_LSB=9, JDO_DATA_LSB=3, JDO_DATA_MSB=34); strobe-kind encoding (NONE, SETADDR_RD, INC_RD, WR).
- One sub-module: pacman_soc_nios2_gen2_0_cpu_debug_ocimem_ram, a single-port synchronous RAM with byte enables, parameterised by ADDR_W.

Test Plan:
- Reset check: after reset, MonDReg=0, MonAReg=0, waitrequest=1, jtag_ovf=0.
- Write then readback: take_action_ocimem_b with jdo[34:3]=0xDEADBEEF at MonAReg=0x10 -> RAM[0x10]=0xDEADBEEF and MonAReg=0x11. Then take_action_ocimem_a with address 0x10 -> MonDReg=0xDEADBEEF two cycles after the strobe.
- Address wrap: MonAReg=0xFF, then take_no_action_ocimem_a -> MonAReg=0x00 and MonDReg=RAM[0x00].
- CPU access: write 0x12345678 at address 0x20 with byteenable=4'b0011 and debugaccess=1 -> RAM[0x20][15:0]=0x5678, upper bytes unchanged. Same write with debugaccess=0 -> no change. CPU read at 0x20 -> waitrequest low exactly at N+2.
- Collision: CPU read and take_action_ocimem_a in the same cycle -> JTAG read completes first; CPU waitrequest stays high until the JTAG op finishes, then the read is served. readdata is correct.
- Overflow and async reset: three strobes within 3 cycles -> first executes, second is pending, third is dropped and jtag_ovf=1. Assert reset_n low during J_RD_CAP -> FSM=IDLE and all outputs return to their reset values asynchronously.
